mem_access_arbiter: RTL

Sequencer and round-robin arbiter that shares a four-word × 5-bit SR-latch memory array between two requesters (A and B). It latches one request at a time, drives the array's word select, write strobe and data with a fixed setup/strobe sequence, captures read data, and returns a one-cycle acknowledge. It sits between the requesting logic and the array's demux/latch datapath. It is the only block that drives the array's write strobe.

---
 rtl/mem_access_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// Round-robin A/B sequencer for a 4x5 latch array; IDLE->SETUP->WRITE/READ->DONE, ack 3 cycles after sampling.
// Losing requester is held off until the next IDLE; MEM_ARB_VERIFY_EN adds a read-back VERIFY cycle to writes.
module mem_access_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [1:0] addr_a,
    input  logic [1:0] addr_b,
    input  logic [4:0] wdata_a,
    input  logic [4:0] wdata_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic [4:0] rdata,
    output logic       busy,
    output logic       err,
    output logic [1:0] mem_sel,
    output logic       mem_we,
    output logic [4:0] mem_wdata,
    input  logic [4:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        VERIFY = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic lat_b;     // 1 = current transaction belongs to B
    logic lat_we;
    logic last_b;    // 1 = B was served last
    logic grant_b;
    logic any_req;

    // B takes a tie only when A was the one served last.
    assign any_req = req_a | req_b;
    assign grant_b = req_b & (~req_a | ~last_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = lat_we ? WRITE : READ;
            end
            WRITE: begin
`ifdef MEM_ARB_VERIFY_EN
                state_nxt = VERIFY;
`else
                state_nxt = DONE;
`endif
            end
            READ: begin
                state_nxt = DONE;
            end
            VERIFY: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // mem_sel/mem_wdata double as the latched address and write data, so they hold in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_b     <= 1'b0;
            lat_we    <= 1'b0;
            last_b    <= 1'b1;
            mem_sel   <= 2'd0;
            mem_wdata <= 5'd0;
            rdata     <= 5'd0;
        end else begin
            if (state == IDLE && any_req) begin
                lat_b     <= grant_b;
                lat_we    <= grant_b ? we_b : we_a;
                mem_sel   <= grant_b ? addr_b : addr_a;
                mem_wdata <= grant_b ? wdata_b : wdata_a;
            end
            if (state == READ) begin
                rdata <= mem_rdata;
            end
            if (state == DONE) begin
                last_b <= lat_b;
            end
        end
    end

`ifdef MEM_ARB_VERIFY_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == VERIFY && mem_rdata != mem_wdata) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Decoded straight from the state register so reset kills the strobe without waiting for an edge.
    assign mem_we = (state == WRITE);
    assign busy   = (state != IDLE);
    assign ack_a  = (state == DONE) & ~lat_b;
    assign ack_b  = (state == DONE) &  lat_b;

endmodule
